// File: rtl/pspin_cmd_scheduler.sv
// Round-robin scheduler of cluster HPU commands onto the command interfaces with per-HPU credit limiting.
// Optional statistics counters are enabled by defining PSPIN_CMD_SCHED_STATS_EN.

package pspin_cfg_pkg;
    localparam int NUM_CLUSTERS       = 2;
    localparam int NUM_CORES          = 8;
    localparam int NUM_CMD_INTERFACES = 3;
    localparam int NUM_HPU_CMDS       = 4;

    typedef struct packed {
        logic [1:0] cluster_id;
        logic [2:0] core_id;
        logic [2:0] local_cmd_id;
    } pspin_cmd_id_t;

    typedef struct packed {
        pspin_cmd_id_t cmd_id;
        logic [1:0]    intf_id;
        logic [15:0]   payload;
    } pspin_cmd_t;
endpackage

module pspin_cmd_scheduler
    import pspin_cfg_pkg::*;
#(
    parameter int NUM_REQ  = NUM_CLUSTERS,
    parameter int NUM_INTF = NUM_CMD_INTERFACES,
    parameter int MAX_INFL = NUM_HPU_CMDS
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    input  pspin_cmd_t [NUM_REQ-1:0]  req_cmd_i,
    output logic [NUM_INTF-1:0]       intf_valid_o,
    input  logic [NUM_INTF-1:0]       intf_ready_i,
    output pspin_cmd_t [NUM_INTF-1:0] intf_cmd_o,
    input  logic                      cmpl_valid_i,
    input  pspin_cmd_id_t             cmpl_id_i,
    output logic                      err_o,
    output logic                      idle_o
`ifdef PSPIN_CMD_SCHED_STATS_EN
    ,
    output logic [NUM_INTF-1:0][31:0] stat_issued_o,
    output logic [31:0]               stat_stall_o
`endif
);

    localparam int CW = $clog2(MAX_INFL + 1);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [CW-1:0] cnt_q [NUM_REQ][NUM_CORES];
    logic [CW-1:0] cnt_d [NUM_REQ][NUM_CORES];
    logic [PW-1:0] rr_ptr_q;
    logic [PW-1:0] rr_ptr_next;

    logic [NUM_REQ-1:0] credit_ok;
    logic [NUM_REQ-1:0] path_ok;
    logic [NUM_REQ-1:0] cid_ok;
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] credit_block;

    logic          grant_any;
    logic [PW-1:0] grant_idx;
    pspin_cmd_t    win_cmd;
    logic          win_bad_intf;

    logic [NUM_INTF-1:0]       valid_d;
    pspin_cmd_t [NUM_INTF-1:0] cmd_d;
    logic                      err_d;
    logic                      idle_d;

    logic unused_cmpl_bits;
    assign unused_cmpl_bits = ^cmpl_id_i.local_cmd_id;

    // Eligibility looks only at registered credit state, so a completion arriving this cycle cannot unblock a full HPU.
    always_comb begin
        credit_ok    = '0;
        path_ok      = '0;
        cid_ok       = '0;
        eligible     = '0;
        credit_block = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            cid_ok[r] = int'(req_cmd_i[r].cmd_id.cluster_id) < NUM_REQ;
            for (int c = 0; c < NUM_REQ; c++) begin
                for (int k = 0; k < NUM_CORES; k++) begin
                    if (int'(req_cmd_i[r].cmd_id.cluster_id) == c &&
                        int'(req_cmd_i[r].cmd_id.core_id) == k) begin
                        credit_ok[r] = cnt_q[c][k] < CW'(MAX_INFL);
                    end
                end
            end
            if (int'(req_cmd_i[r].intf_id) >= NUM_INTF) begin
                path_ok[r] = 1'b1;
            end else begin
                for (int i = 0; i < NUM_INTF; i++) begin
                    if (int'(req_cmd_i[r].intf_id) == i) begin
                        path_ok[r] = !intf_valid_o[i] || intf_ready_i[i];
                    end
                end
            end
            eligible[r]     = req_valid_i[r] && !rst_i && credit_ok[r] && path_ok[r];
            credit_block[r] = req_valid_i[r] && !rst_i && cid_ok[r] && !credit_ok[r] && path_ok[r];
        end
    end

    always_comb begin
        grant_any   = 1'b0;
        grant_idx   = '0;
        req_ready_o = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            for (int r = 0; r < NUM_REQ; r++) begin
                if (r == (int'(rr_ptr_q) + off) % NUM_REQ && eligible[r] && !grant_any) begin
                    grant_any = 1'b1;
                    grant_idx = PW'(r);
                end
            end
        end
        if (grant_any) begin
            req_ready_o[grant_idx] = 1'b1;
        end
    end

    assign win_cmd      = req_cmd_i[grant_idx];
    assign win_bad_intf = int'(win_cmd.intf_id) >= NUM_INTF;
    assign rr_ptr_next  = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;

    // A matching grant and completion on one counter cancel out, so neither counting nor underflow applies.
    always_comb begin
        logic inc;
        logic dec;
        inc     = 1'b0;
        dec     = 1'b0;
        valid_d = intf_valid_o;
        cmd_d   = intf_cmd_o;
        err_d   = 1'b0;
        idle_d  = 1'b1;
        for (int i = 0; i < NUM_INTF; i++) begin
            if (intf_valid_o[i] && intf_ready_i[i]) begin
                valid_d[i] = 1'b0;
                cmd_d[i]   = '0;
            end
            if (grant_any && !win_bad_intf && int'(win_cmd.intf_id) == i) begin
                valid_d[i] = 1'b1;
                cmd_d[i]   = win_cmd;
            end
        end
        if (grant_any && win_bad_intf) begin
            err_d = 1'b1;
        end
        if (cmpl_valid_i && int'(cmpl_id_i.cluster_id) >= NUM_REQ) begin
            err_d = 1'b1;
        end
        for (int c = 0; c < NUM_REQ; c++) begin
            for (int k = 0; k < NUM_CORES; k++) begin
                inc = grant_any && !win_bad_intf &&
                      int'(win_cmd.cmd_id.cluster_id) == c && int'(win_cmd.cmd_id.core_id) == k;
                dec = cmpl_valid_i &&
                      int'(cmpl_id_i.cluster_id) == c && int'(cmpl_id_i.core_id) == k;
                cnt_d[c][k] = cnt_q[c][k];
                if (inc && !dec) begin
                    cnt_d[c][k] = cnt_q[c][k] + 1'b1;
                end else if (dec && !inc) begin
                    if (cnt_q[c][k] == '0) begin
                        err_d = 1'b1;
                    end else begin
                        cnt_d[c][k] = cnt_q[c][k] - 1'b1;
                    end
                end
                if (cnt_d[c][k] != '0) begin
                    idle_d = 1'b0;
                end
            end
        end
        if (valid_d != '0) begin
            idle_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr_q     <= '0;
            intf_valid_o <= '0;
            intf_cmd_o   <= '0;
            err_o        <= 1'b0;
            idle_o       <= 1'b1;
            for (int c = 0; c < NUM_REQ; c++) begin
                for (int k = 0; k < NUM_CORES; k++) begin
                    cnt_q[c][k] <= '0;
                end
            end
        end else begin
            if (grant_any) begin
                rr_ptr_q <= rr_ptr_next;
            end
            intf_valid_o <= valid_d;
            intf_cmd_o   <= cmd_d;
            err_o        <= err_d;
            idle_o       <= idle_d;
            for (int c = 0; c < NUM_REQ; c++) begin
                for (int k = 0; k < NUM_CORES; k++) begin
                    cnt_q[c][k] <= cnt_d[c][k];
                end
            end
        end
    end

`ifdef PSPIN_CMD_SCHED_STATS_EN
    // Stall cycles count requests that would have gone out if only their HPU had a free credit.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stat_issued_o <= '0;
            stat_stall_o  <= '0;
        end else begin
            for (int i = 0; i < NUM_INTF; i++) begin
                if (intf_valid_o[i] && intf_ready_i[i]) begin
                    stat_issued_o[i] <= stat_issued_o[i] + 32'd1;
                end
            end
            if (|credit_block) begin
                stat_stall_o <= stat_stall_o + 32'd1;
            end
        end
    end
`else
    logic unused_stats;
    assign unused_stats = ^credit_block;
`endif

endmodule

// File: tb/tb_pspin_cmd_scheduler.sv
// Self-checking bench for pspin_cmd_scheduler: cycle model compared every cycle plus directed literal checks.

module tb_pspin_cmd_scheduler;
    import pspin_cfg_pkg::*;

    localparam int NREQ    = 2;
    localparam int NINTF   = 3;
    localparam int NCORES  = 8;
    localparam int MAXINFL = 4;

    logic                  clk;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready_o;
    pspin_cmd_t [NREQ-1:0] req_cmd;
    logic [NINTF-1:0]      intf_valid_o;
    logic [NINTF-1:0]      intf_ready;
    pspin_cmd_t [NINTF-1:0] intf_cmd_o;
    logic                  cmpl_valid;
    pspin_cmd_id_t         cmpl_id;
    logic                  err_o;
    logic                  idle_o;
`ifdef PSPIN_CMD_SCHED_STATS_EN
    logic [NINTF-1:0][31:0] stat_issued;
    logic [31:0]            stat_stall;
`endif

    int tests_run  = 0;
    int fail_count = 0;

    pspin_cmd_scheduler #(.NUM_REQ(NREQ), .NUM_INTF(NINTF), .MAX_INFL(MAXINFL)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready_o),
        .req_cmd_i   (req_cmd),
        .intf_valid_o(intf_valid_o),
        .intf_ready_i(intf_ready),
        .intf_cmd_o  (intf_cmd_o),
        .cmpl_valid_i(cmpl_valid),
        .cmpl_id_i   (cmpl_id),
        .err_o       (err_o),
        .idle_o      (idle_o)
`ifdef PSPIN_CMD_SCHED_STATS_EN
        ,
        .stat_issued_o(stat_issued),
        .stat_stall_o (stat_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: what the registered outputs must be after the most recent edge.
    int         m_credit [NREQ][NCORES];
    bit         m_valid  [NINTF];
    pspin_cmd_t m_cmd    [NINTF];
    int         m_ptr;
    bit         m_err;
    bit         m_idle;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
        end
    endtask

    function automatic pspin_cmd_t mk(int cl, int co, int lid, int intf, int pay);
        pspin_cmd_t c;
        c.cmd_id.cluster_id   = 2'(cl);
        c.cmd_id.core_id      = 3'(co);
        c.cmd_id.local_cmd_id = 3'(lid);
        c.intf_id             = 2'(intf);
        c.payload             = 16'(pay);
        return c;
    endfunction

    function automatic pspin_cmd_id_t mkid(int cl, int co);
        pspin_cmd_id_t id;
        id.cluster_id   = 2'(cl);
        id.core_id      = 3'(co);
        id.local_cmd_id = 3'd0;
        return id;
    endfunction

    function automatic bit modelEligible(int r);
        int cl;
        int co;
        int it;
        cl = int'(req_cmd[r].cmd_id.cluster_id);
        co = int'(req_cmd[r].cmd_id.core_id);
        it = int'(req_cmd[r].intf_id);
        if (!req_valid[r] || cl >= NREQ) return 1'b0;
        if (m_credit[cl][co] >= MAXINFL) return 1'b0;
        if (it < NINTF && m_valid[it] && !intf_ready[it]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic modelReset();
        for (int c = 0; c < NREQ; c++)
            for (int k = 0; k < NCORES; k++) m_credit[c][k] = 0;
        for (int i = 0; i < NINTF; i++) begin
            m_valid[i] = 1'b0;
            m_cmd[i]   = '0;
        end
        m_ptr  = 0;
        m_err  = 1'b0;
        m_idle = 1'b1;
    endtask

    // Single compare process: checks all outputs mid-cycle, then advances the model across the coming edge.
    always @(negedge clk) begin
        int              w;
        int              cand;
        int              cc;
        int              ck;
        int              wi;
        bit              same;
        bit              err_next;
        logic [NREQ-1:0] exp_ready;
        pspin_cmd_t      wc;
        if (rst) modelReset();
        for (int i = 0; i < NINTF; i++) begin
            checkOutput($sformatf("intf_valid[%0d]", i), 64'(intf_valid_o[i]), 64'(m_valid[i]));
            checkOutput($sformatf("intf_cmd[%0d]", i), 64'(intf_cmd_o[i]), 64'(m_cmd[i]));
        end
        checkOutput("err", 64'(err_o), 64'(m_err));
        checkOutput("idle", 64'(idle_o), 64'(m_idle));
        w = -1;
        if (!rst) begin
            for (int n = 0; n < NREQ; n++) begin
                cand = (m_ptr + n) % NREQ;
                if (w < 0 && modelEligible(cand)) w = cand;
            end
        end
        exp_ready = '0;
        if (w >= 0) exp_ready[w] = 1'b1;
        checkOutput("req_ready", 64'(req_ready_o), 64'(exp_ready));
        if (!rst) begin
            err_next = 1'b0;
            same     = 1'b0;
            wc       = '0;
            wi       = 0;
            if (w >= 0) begin
                wc = req_cmd[w];
                wi = int'(wc.intf_id);
            end
            if (cmpl_valid) begin
                cc = int'(cmpl_id.cluster_id);
                ck = int'(cmpl_id.core_id);
                if (cc >= NREQ) begin
                    err_next = 1'b1;
                end else begin
                    same = (w >= 0) && (wi < NINTF) &&
                           int'(wc.cmd_id.cluster_id) == cc && int'(wc.cmd_id.core_id) == ck;
                    if (!same) begin
                        if (m_credit[cc][ck] == 0) err_next = 1'b1;
                        else m_credit[cc][ck] = m_credit[cc][ck] - 1;
                    end
                end
            end
            for (int i = 0; i < NINTF; i++) begin
                if (m_valid[i] && intf_ready[i]) begin
                    m_valid[i] = 1'b0;
                    m_cmd[i]   = '0;
                end
            end
            if (w >= 0) begin
                if (wi >= NINTF) begin
                    err_next = 1'b1;
                end else begin
                    m_valid[wi] = 1'b1;
                    m_cmd[wi]   = wc;
                    if (!same) begin
                        cc = int'(wc.cmd_id.cluster_id);
                        ck = int'(wc.cmd_id.core_id);
                        m_credit[cc][ck] = m_credit[cc][ck] + 1;
                    end
                end
                m_ptr = (w + 1) % NREQ;
            end
            m_err  = err_next;
            m_idle = 1'b1;
            for (int c = 0; c < NREQ; c++)
                for (int k = 0; k < NCORES; k++)
                    if (m_credit[c][k] != 0) m_idle = 1'b0;
            for (int i = 0; i < NINTF; i++)
                if (m_valid[i]) m_idle = 1'b0;
        end
    end

    task automatic applyStimulus(input logic [NREQ-1:0] v, input pspin_cmd_t c0, input pspin_cmd_t c1,
                                 input logic [NINTF-1:0] rdy, input logic cv, input pspin_cmd_id_t cid);
        @(posedge clk);
        #2;
        req_valid  = v;
        req_cmd[0] = c0;
        req_cmd[1] = c1;
        intf_ready = rdy;
        cmpl_valid = cv;
        cmpl_id    = cid;
        #1;
    endtask

    task automatic idleCycle();
        applyStimulus('0, '0, '0, '1, 1'b0, '0);
    endtask

    task automatic complete(input int cl, input int co);
        applyStimulus('0, '0, '0, '1, 1'b1, mkid(cl, co));
    endtask

    pspin_cmd_t c_a;
    pspin_cmd_t c_b;

    initial begin
        rst        = 1'b1;
        req_valid  = '0;
        req_cmd    = '0;
        intf_ready = '1;
        cmpl_valid = 1'b0;
        cmpl_id    = '0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("reset_idle", 64'(idle_o), 64'd1);
        checkOutput("reset_valid", 64'(intf_valid_o), 64'd0);
        checkOutput("reset_err", 64'(err_o), 64'd0);

        // Single command: cluster0 core3 to interface 1.
        c_a = mk(0, 3, 0, 1, 'h11);
        applyStimulus(2'b01, c_a, '0, '1, 1'b0, '0);
        checkOutput("t1_ready", 64'(req_ready_o), 64'b01);
        idleCycle();
        checkOutput("t1_valid", 64'(intf_valid_o), 64'b010);
        checkOutput("t1_cmd", 64'(intf_cmd_o[1]), 64'(c_a));
        checkOutput("t1_busy", 64'(idle_o), 64'd0);
        idleCycle();
        checkOutput("t1_drained", 64'(intf_valid_o), 64'd0);
        complete(0, 3);
        idleCycle();
        checkOutput("t1_idle", 64'(idle_o), 64'd1);

        // Credit limit: fifth command for cluster0 core2 waits for a completion.
        for (int k = 0; k < 4; k++) begin
            applyStimulus(2'b01, mk(0, 2, k, 0, k), '0, '1, 1'b0, '0);
            checkOutput("t2_grant", 64'(req_ready_o), 64'b01);
        end
        c_a = mk(0, 2, 4, 0, 'h44);
        for (int k = 0; k < 2; k++) begin
            applyStimulus(2'b01, c_a, '0, '1, 1'b0, '0);
            checkOutput("t2_stall", 64'(req_ready_o), 64'b00);
        end
        applyStimulus(2'b01, c_a, '0, '1, 1'b1, mkid(0, 2));
        checkOutput("t2_cmpl_cycle", 64'(req_ready_o), 64'b00);
        applyStimulus(2'b01, c_a, '0, '1, 1'b0, '0);
        checkOutput("t2_released", 64'(req_ready_o), 64'b01);
        for (int k = 0; k < 4; k++) complete(0, 2);
        idleCycle();
        checkOutput("t2_idle", 64'(idle_o), 64'd1);

        // Two clusters contending for interface 2: grants alternate, pointer starts at 1.
        c_a = mk(0, 1, 0, 2, 'hA0);
        c_b = mk(1, 1, 0, 2, 'hB0);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(2'b11, c_a, c_b, '1, 1'b0, '0);
            checkOutput("t3_rr", 64'(req_ready_o), (k % 2 == 0) ? 64'b10 : 64'b01);
            if (k > 0) checkOutput("t3_stream", 64'(intf_valid_o[2]), 64'd1);
        end
        idleCycle();
        checkOutput("t3_last", 64'(intf_cmd_o[2]), 64'(c_a));
        complete(0, 1);
        complete(0, 1);
        complete(1, 1);
        complete(1, 1);
        idleCycle();
        checkOutput("t3_idle", 64'(idle_o), 64'd1);

        // Backpressure on interface 0 holds its command; an interface-1 request bypasses it.
        c_a = mk(0, 4, 0, 0, 'hC4);
        c_b = mk(0, 5, 0, 0, 'hC5);
        applyStimulus(2'b01, c_a, '0, 3'b110, 1'b0, '0);
        checkOutput("t4_first", 64'(req_ready_o), 64'b01);
        applyStimulus(2'b11, c_b, mk(1, 4, 0, 1, 'hD4), 3'b110, 1'b0, '0);
        checkOutput("t4_bypass", 64'(req_ready_o), 64'b10);
        checkOutput("t4_hold0", 64'(intf_cmd_o[0]), 64'(c_a));
        for (int k = 0; k < 2; k++) begin
            applyStimulus(2'b01, c_b, '0, 3'b110, 1'b0, '0);
            checkOutput("t4_wait", 64'(req_ready_o), 64'b00);
            checkOutput("t4_hold", 64'(intf_cmd_o[0]), 64'(c_a));
        end
        applyStimulus(2'b01, c_b, '0, '1, 1'b0, '0);
        checkOutput("t4_reload", 64'(req_ready_o), 64'b01);
        idleCycle();
        checkOutput("t4_next_cmd", 64'(intf_cmd_o[0]), 64'(c_b));
        checkOutput("t4_next_valid", 64'(intf_valid_o[0]), 64'd1);
        complete(0, 4);
        complete(0, 5);
        complete(1, 4);
        idleCycle();
        checkOutput("t4_idle", 64'(idle_o), 64'd1);

        // Invalid interface id: granted, dropped, error pulse, no credit taken.
        applyStimulus(2'b10, '0, mk(1, 6, 0, 3, 'hE6), '1, 1'b0, '0);
        checkOutput("t5_grant", 64'(req_ready_o), 64'b10);
        idleCycle();
        checkOutput("t5_err", 64'(err_o), 64'd1);
        checkOutput("t5_novalid", 64'(intf_valid_o), 64'd0);
        checkOutput("t5_idle", 64'(idle_o), 64'd1);
        idleCycle();
        checkOutput("t5_err_clear", 64'(err_o), 64'd0);

        // Underflow and out-of-range completions.
        complete(1, 7);
        idleCycle();
        checkOutput("t6_underflow", 64'(err_o), 64'd1);
        checkOutput("t6_idle", 64'(idle_o), 64'd1);
        idleCycle();
        checkOutput("t6_err_clear", 64'(err_o), 64'd0);
        complete(2, 0);
        idleCycle();
        checkOutput("t6_bad_cluster", 64'(err_o), 64'd1);

        // Grant and completion on one counter in the same cycle net to zero: 5 grants with 1 completion fill it.
        for (int k = 0; k < 5; k++) begin
            applyStimulus(2'b01, mk(0, 0, k, 1, 'hF0 + k), '0, '1, (k == 2), mkid(0, 0));
            checkOutput("t6_grant", 64'(req_ready_o), 64'b01);
        end
        applyStimulus(2'b01, mk(0, 0, 5, 1, 'hF5), '0, '1, 1'b0, '0);
        checkOutput("t6_full", 64'(req_ready_o), 64'b00);
        for (int k = 0; k < 4; k++) complete(0, 0);
        idleCycle();
        checkOutput("t6_idle_end", 64'(idle_o), 64'd1);

        // Reset with a held command and an outstanding credit; the late completion underflows.
        applyStimulus(2'b01, mk(0, 6, 0, 0, 'h77), '0, 3'b110, 1'b0, '0);
        applyStimulus('0, '0, '0, 3'b110, 1'b0, '0);
        checkOutput("t7_pending", 64'(intf_valid_o[0]), 64'd1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("t7_rst_valid", 64'(intf_valid_o), 64'd0);
        checkOutput("t7_rst_idle", 64'(idle_o), 64'd1);
        @(posedge clk);
        #2;
        rst = 1'b0;
        complete(0, 6);
        idleCycle();
        checkOutput("t7_late_err", 64'(err_o), 64'd1);
        checkOutput("t7_late_idle", 64'(idle_o), 64'd1);
        idleCycle();
        checkOutput("t7_err_clear", 64'(err_o), 64'd0);

        repeat (2) idleCycle();
        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end

endmodule
